// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction
// memory and fills the IF/ID register, honouring the single branch-delay slot.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid,
    output logic [31:0] pc
);

    // state  | meaning
    // S_REQ  | fetch at pc outstanding, imem_req high
    // S_HELD | fetched word parked in hbuf, waiting for ID to accept it
    typedef enum logic {S_REQ, S_HELD} state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] hbuf;
    logic        redir_v;
    logic [31:0] redir_tgt;

    logic [31:0] pc4;
    logic [31:0] tgt_sel;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        take;
    logic        advance;

    assign pc4 = pc + 32'd4;

    always_comb begin
        tgt_sel = pc4;
        case (pcsource)
            2'b01:   tgt_sel = bpc;
            2'b10:   tgt_sel = rpc;
            2'b11:   tgt_sel = jpc;
            default: tgt_sel = pc4;
        endcase
    end

    assign tgt  = {tgt_sel[31:2], 2'b00};
    assign take = wpcir & dvalid & (pcsource != 2'b00);

    // A redirect seen while the delay-slot fetch is still pending is parked
    // in redir_tgt and applied when that slot finally advances the PC.
    assign npc = take ? tgt : (redir_v ? redir_tgt : pc4);

    assign advance = wpcir & (((state == S_REQ) & imem_ack) | (state == S_HELD));

    assign imem_req  = (state == S_REQ) & ~reset;
    assign imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= PC_INIT;
            inst      <= 32'd0;
            dpc4      <= 32'd0;
            dvalid    <= 1'b0;
            hbuf      <= 32'd0;
            redir_v   <= 1'b0;
            redir_tgt <= 32'd0;
        end else begin
            if (advance) begin
                pc      <= npc;
                redir_v <= 1'b0;
            end else if (take) begin
                redir_v   <= 1'b1;
                redir_tgt <= tgt;
            end

            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        if (wpcir) begin
                            inst   <= imem_rdata;
                            dpc4   <= pc4;
                            dvalid <= 1'b1;
                        end else begin
                            hbuf  <= imem_rdata;
                            state <= S_HELD;
                        end
                    end else if (wpcir) begin
                        inst   <= 32'd0;
                        dvalid <= 1'b0;
                    end
                end
                S_HELD: begin
                    if (wpcir) begin
                        inst   <= hbuf;
                        dpc4   <= pc4;
                        dvalid <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Randomized bench for pipe_fetch: memory/ID driver feeds an architectural
// next-address model; a separate monitor checks IF/ID against its queue.
`timescale 1ns/1ps
module tb_pipe_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, rpc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst, dpc4, pc;
    logic        dvalid;

    pipe_fetch #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .pcsource(pcsource),
        .bpc(bpc), .jpc(jpc), .rpc(rpc), .wpcir(wpcir),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .dpc4(dpc4), .dvalid(dvalid),
        .pc(pc)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_cur;
    logic        m_pend;
    logic [31:0] m_tgt;
    bit          zero_wait;
    bit          branches_on;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
        return h | 32'h1;
    endfunction

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF8;
            default: return 32'($urandom_range(0, 1023)) * 4;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RPC);
        m_cur  = RPC;
        m_pend = 1'b0;
        m_tgt  = 32'd0;
    endtask

    // Memory responder + ID-stage model; sequence rule: the instruction two
    // after a taken branch comes from its target, otherwise addresses step by 4.
    initial begin
        logic [31:0] nxt;
        logic [31:0] sel;
        forever begin
            @(negedge clock);
            if (reset) begin
                imem_ack   = 1'b0;
                imem_rdata = 32'd0;
                wpcir      = 1'b0;
                pcsource   = 2'b00;
            end else begin
                imem_ack   = imem_req && (zero_wait || $urandom_range(0, 99) < 55);
                imem_rdata = imem_ack ? memword(imem_addr) : $urandom;
                wpcir      = zero_wait || ($urandom_range(0, 99) < 75);
                bpc        = rand_tgt();
                jpc        = rand_tgt();
                rpc        = rand_tgt();
                pcsource   = (branches_on && $urandom_range(0, 99) < 35) ?
                             2'($urandom_range(1, 3)) : 2'b00;
                if (dvalid && wpcir) begin
                    nxt = m_pend ? m_tgt : m_cur + 32'd4;
                    case (pcsource)
                        2'b01:   sel = bpc;
                        2'b10:   sel = rpc;
                        2'b11:   sel = jpc;
                        default: sel = 32'd0;
                    endcase
                    m_pend = (pcsource != 2'b00);
                    m_tgt  = {sel[31:2], 2'b00};
                    m_cur  = nxt;
                    exp_q.push_back(nxt);
                    consumed++;
                end
            end
        end
    end

    // Monitor: samples after inputs settle, well away from the rising edge.
    initial begin
        logic        p_ok;
        logic        p_req, p_ack, p_w, p_dv;
        logic [31:0] p_inst, p_dpc4, p_addr;
        logic [31:0] a;
        p_ok = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                p_ok = 1'b0;
            end else begin
                check32("addr_eq_pc", imem_addr, pc);
                check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (!dvalid) check32("bubble_inst_zero", inst, 32'd0);
                if (p_ok) begin
                    if (p_req && !p_ack) begin
                        check32("req_stays_high", {31'd0, imem_req}, 32'd1);
                        check32("addr_stable", imem_addr, p_addr);
                    end
                    if (p_req && !p_ack && p_w)
                        check32("wait_bubble", {31'd0, dvalid}, 32'd0);
                    if (!p_w) begin
                        check32("hold_inst", inst, p_inst);
                        check32("hold_dpc4", dpc4, p_dpc4);
                        check32("hold_dvalid", {31'd0, dvalid}, {31'd0, p_dv});
                    end
                    if (p_req && p_ack && !p_w)
                        check32("held_req_low", {31'd0, imem_req}, 32'd0);
                    if ((p_req && p_ack && p_w) || (!p_req && p_w))
                        check32("load_valid", {31'd0, dvalid}, 32'd1);
                end
                if (dvalid && wpcir) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got valid inst %h expected none", inst);
                    end else begin
                        a = exp_q.pop_front();
                        check32("if_inst", inst, memword(a));
                        check32("if_dpc4", dpc4, a + 32'd4);
                    end
                end
                p_ok   = 1'b1;
                p_req  = imem_req;
                p_ack  = imem_ack;
                p_w    = wpcir;
                p_dv   = dvalid;
                p_inst = inst;
                p_dpc4 = dpc4;
                p_addr = imem_addr;
            end
        end
    end

    initial begin
        int waited;
        reset       = 1'b1;
        pcsource    = 2'b00;
        bpc         = 32'd0;
        jpc         = 32'd0;
        rpc         = 32'd0;
        wpcir       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        zero_wait   = 1'b1;
        branches_on = 1'b0;
        model_reset();

        repeat (2) @(negedge clock);
        #1;
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_pc", pc, RPC);
        check32("rst_inst", inst, 32'd0);
        check32("rst_dpc4", dpc4, 32'd0);
        check32("rst_dvalid", {31'd0, dvalid}, 32'd0);

        @(negedge clock);
        #5 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #3;
            check32("seq_addr", imem_addr, RPC + 32'(4 * i));
        end
        repeat (10) @(negedge clock);

        zero_wait = 1'b0;
        repeat (150) @(negedge clock);
        branches_on = 1'b1;
        repeat (3000) @(negedge clock);

        waited = 0;
        @(negedge clock);
        #5;
        while (!imem_req && waited < 50) begin
            @(negedge clock);
            #5;
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_req_timeout: got no request in %0d cycles expected one", waited);
        end
        reset = 1'b1;
        model_reset();
        #1;
        check32("midrst_req", {31'd0, imem_req}, 32'd0);
        check32("midrst_pc", pc, RPC);
        check32("midrst_inst", inst, 32'd0);
        check32("midrst_dpc4", dpc4, 32'd0);
        check32("midrst_dvalid", {31'd0, dvalid}, 32'd0);
        repeat (3) @(negedge clock);
        #5 reset = 1'b0;
        #1;
        check32("post_rst_req", {31'd0, imem_req}, 32'd1);
        check32("post_rst_addr", imem_addr, RPC);
        repeat (800) @(negedge clock);

        checks++;
        if (consumed < 800) begin
            errors++;
            $display("FAIL progress: got %0d instructions expected at least 800", consumed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction-fetch stage of the five-stage pipelined CPU. It owns the program counter, drives a request/acknowledge instruction-memory port and fills the IF/ID pipeline register that the decode stage reads (`inst`, `dpc4`). It consumes the decode stage's next-PC controls (`pcsource`, `bpc`, `jpc`, register target) and its stall line `wpcir`, and it implements the single MIPS branch-delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pcsource`  in  2  next-PC select from ID: 00 = sequential, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`  in  32  branch target from ID.
- `jpc`  in  32  jump target from ID.
- `rpc`  in  32  register jump target (ID forwarded `da`).
- `wpcir`  in  1  1 = ID accepts IF/ID this edge; 0 = ID stalled, IF/ID must hold.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`; bits [1:0] are always 0.
- `imem_ack`  in  1  one-cycle acknowledge; `imem_rdata` is valid in that cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `inst`  out  32  IF/ID instruction register.
- `dpc4`  out  32  IF/ID register holding that instruction's PC+4.
- `dvalid`  out  1  IF/ID holds a real instruction (0 = bubble; `inst` = 0).
- `pc`  out  32  address currently being fetched or held.

## Operation
- Invariant: `pc` is the address following the last valid instruction loaded into IF/ID.
- State machine with two states:
  - REQ: `imem_req` = 1.
  - HELD: the fetched word is parked in the 32-bit `hbuf`; `imem_req` = 0.
- REQ with `imem_ack`:
  - If `wpcir` = 1: `inst` <= `imem_rdata`, `dpc4` <= `pc`+4, `dvalid` <= 1, `pc` <= `npc`; stay in REQ.
  - If `wpcir` = 0: `hbuf` <= `imem_rdata`; go to HELD.
- REQ without `imem_ack`:
  - If `wpcir` = 1: load a bubble (`inst` <= 0, `dvalid` <= 0, `dpc4` unchanged).
  - If `wpcir` = 0: hold IF/ID.
- HELD:
  - If `wpcir` = 1: IF/ID <= {`hbuf`, `pc`+4, 1}, `pc` <= `npc`; go to REQ.
  - Otherwise hold everything.
- Redirect capture:
  - `take` = `wpcir` & `dvalid` & (`pcsource` != 00).
  - `tgt` = the target selected by `pcsource`, with bits [1:0] forced to 00.
  - On a `take` edge that does not also advance `pc`, set `redir_v` <= 1 and `redir_tgt` <= `tgt`.
- `npc` = `take` ? `tgt` : `redir_v` ? `redir_tgt` : `pc`+4.
- `redir_v` clears on every edge that advances `pc`.
- Delay slot: when the branch is in ID, the instruction at `pc` (in flight or held) is its delay slot. That instruction always issues, and the redirect applies to the fetch after it.
- Simultaneous `take` and `pc` advance: use `tgt` directly; nothing is latched.
- `pcsource` is ignored whenever `dvalid` = 0 or `wpcir` = 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; state = REQ.
  - `inst` = 0, `dpc4` = 0, `dvalid` = 0.
  - `redir_v` = 0, `redir_tgt` = 0, `hbuf` = 0.
- While `reset` = 1, `imem_req` = 0 and `imem_ack` is ignored. An in-flight fetch is abandoned; memory must drop the transaction when `imem_req` falls.
- Handshake:
  - `imem_addr` is stable while `imem_req` = 1 until the ack.
  - Ack is allowed in the same cycle as the request (zero wait).
  - One fetch is outstanding at a time.
- Zero-wait memory with `wpcir` = 1 sustains one instruction per cycle. `imem_req` stays high and `imem_addr` changes the cycle after each ack.
- Latency: an ack at edge N makes the word visible on `inst` after edge N.
- Each memory wait cycle inserts exactly one bubble when `wpcir` = 1.

## Test plan
- Sequential fetch: `RESET_PC`=0, zero-wait memory, `wpcir`=1 -> `imem_addr` 0,4,8,C on consecutive cycles; `dpc4` 4,8,C,10; `dvalid`=1 from the first post-ack cycle.
- Wait states: 2-cycle ack latency, `wpcir`=1 -> each instruction is preceded by 1 bubble (`dvalid`=0, `inst`=0); `pc` advances by 4 per ack.
- Stall with hold: word at 0x8 acked while `wpcir`=0 for 3 cycles -> `imem_req`=0 during HELD, IF/ID unchanged; after `wpcir`=1, `inst`=mem[0x8], then fetch resumes at 0xC.
- Branch with delay slot: branch at 0x10 in ID, `pcsource`=01, `bpc`=0x40, zero-wait -> IF/ID sequence 0x10, 0x14 (slot), 0x40, 0x44.
- Redirect latched: `jpc`=0x100 taken while the slot fetch at 0x24 waits 3 cycles -> `redir_v`=1; after the slot ack the next `imem_addr` is 0x100 and `redir_v` returns to 0.
- Reset mid-fetch: assert `reset` while `imem_req`=1 at 0x30 -> `imem_req`=0 immediately; all registers at reset values; after release the first fetch is at `RESET_PC`.
